// File: rtl/fwd_source_tracker.sv
// fwd_source_tracker
//   Producer side of the operand-forwarding bus. Each issue pipe owns a short
//   shift register of in-flight results (m1 -> m2 -> wb). Every entry is
//   published on forwarding_bus_o so consumers can match source registers.
//   Results that are not final when they leave ex (loads, multiplies) are
//   marked not-ready. They are completed when the late result arrives at
//   LATE_STAGE. pending_o lists registers whose value is still unknown.
//
// Ports
//   clk              clock
//   rst_n            synchronous active-low reset
//   stall_i          hold all entries in place
//   flush_i          kill the uncommitted (m1) entries
//   ex_valid_i       per pipe: instruction leaving ex writes a register
//   ex_addr_i        per pipe: destination register
//   ex_data_i        per pipe: ex result
//   ex_ready_i       per pipe: ex_data_i is final
//   late_valid_i     per pipe: late result for the entry at LATE_STAGE
//   late_data_i      per pipe: late result value
//   forwarding_bus_o [pipe][stage] = {valid, ready, addr[4:0], data}
//                    stage STAGE_NUM-1 = m1 (youngest), stage 0 = wb (oldest)
//   pending_o        bit r set if a valid, not-ready entry targets r

module fwd_source_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGE_NUM  = 3,
  parameter int PIPE_NUM   = 2,
  parameter int LATE_STAGE = 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              stall_i,
  input  logic                                              flush_i,
  input  logic [PIPE_NUM-1:0]                               ex_valid_i,
  input  logic [PIPE_NUM-1:0][4:0]                          ex_addr_i,
  input  logic [PIPE_NUM-1:0][DATA_WIDTH-1:0]               ex_data_i,
  input  logic [PIPE_NUM-1:0]                               ex_ready_i,
  input  logic [PIPE_NUM-1:0]                               late_valid_i,
  input  logic [PIPE_NUM-1:0][DATA_WIDTH-1:0]               late_data_i,
  output logic [PIPE_NUM-1:0][STAGE_NUM-1:0][DATA_WIDTH+6:0] forwarding_bus_o,
  output logic [31:0]                                       pending_o
);

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [4:0]            addr;
    logic [DATA_WIDTH-1:0] data;
  } forwarding_data_t;

  forwarding_data_t [PIPE_NUM-1:0][STAGE_NUM-1:0] entry_q;
  forwarding_data_t [PIPE_NUM-1:0][STAGE_NUM-1:0] entry_d;
  logic             [PIPE_NUM-1:0]                late_hit;

  // A late result only completes a live entry that is still waiting for it;
  // anything else on late_valid_i is dropped.
  always_comb begin
    late_hit = '0;
    for (int p = 0; p < PIPE_NUM; p++) begin
      late_hit[p] = late_valid_i[p] && entry_q[p][LATE_STAGE].valid &&
                    !entry_q[p][LATE_STAGE].ready;
    end
  end

  // Next-state of the whole tracker. While stalled, entries stay put and only
  // in-place updates happen (flush kills m1, late data completes LATE_STAGE).
  // Otherwise everything shifts one stage towards wb. The late result and the
  // flush are applied to the entry as it moves so the new stage carries them.
  always_comb begin
    entry_d = entry_q;
    for (int p = 0; p < PIPE_NUM; p++) begin
      if (stall_i) begin
        if (flush_i) begin
          entry_d[p][STAGE_NUM-1].valid = 1'b0;
        end
        if (late_hit[p]) begin
          entry_d[p][LATE_STAGE].data  = late_data_i[p];
          entry_d[p][LATE_STAGE].ready = 1'b1;
        end
      end else begin
        for (int s = 0; s < STAGE_NUM - 1; s++) begin
          entry_d[p][s] = entry_q[p][s+1];
          if ((s + 1 == LATE_STAGE) && late_hit[p]) begin
            entry_d[p][s].data  = late_data_i[p];
            entry_d[p][s].ready = 1'b1;
          end
          if ((s == STAGE_NUM - 2) && flush_i) begin
            entry_d[p][s].valid = 1'b0;
          end
        end
        // r0 is hard-wired zero, so writes to it never need forwarding.
        entry_d[p][STAGE_NUM-1].valid = ex_valid_i[p] && (ex_addr_i[p] != 5'd0) &&
                                        !flush_i;
        entry_d[p][STAGE_NUM-1].ready = ex_ready_i[p];
        entry_d[p][STAGE_NUM-1].addr  = ex_addr_i[p];
        entry_d[p][STAGE_NUM-1].data  = ex_data_i[p];
      end
    end
  end

  // Reset wins over stall and flush and discards every in-flight entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign forwarding_bus_o = entry_q;

  // Registers still waiting on a late result; issue stalls on these.
  always_comb begin
    pending_o = '0;
    for (int p = 0; p < PIPE_NUM; p++) begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (entry_q[p][s].valid && !entry_q[p][s].ready) begin
          pending_o[entry_q[p][s].addr] = 1'b1;
        end
      end
    end
    pending_o[0] = 1'b0;
  end

  // A not-ready result reaching wb means the late data never arrived.
  for (genvar p = 0; p < PIPE_NUM; p++) begin : g_wb_check
    wb_ready_check : assert property (@(posedge clk) disable iff (!rst_n)
      !(entry_q[p][0].valid && !entry_q[p][0].ready));
  end

endmodule

// File: tb/tb_fwd_source_tracker.sv
// tb_fwd_source_tracker
//   Directed scenarios for capture, late loads, r0 filtering, stall, flush and
//   reset, followed by a randomized run against a stage-list reference model.

module tb_fwd_source_tracker;

  localparam int DW = 32;
  localparam int SN = 3;
  localparam int PN = 2;
  localparam int EW = DW + 7;

  typedef struct packed {
    logic          valid;
    logic          ready;
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } rec_t;

  logic                           clk;
  logic                           rst_n;
  logic                           stall;
  logic                           flush;
  logic [PN-1:0]                  ex_valid;
  logic [PN-1:0][4:0]             ex_addr;
  logic [PN-1:0][DW-1:0]          ex_data;
  logic [PN-1:0]                  ex_ready;
  logic [PN-1:0]                  late_valid;
  logic [PN-1:0][DW-1:0]          late_data;
  logic [PN-1:0][SN-1:0][EW-1:0]  bus;
  logic [31:0]                    pending;

  int passed;
  int total;

  // Reference model: per pipe, a list ordered by age. Slot 0 is the newest
  // result (m1), slot 1 is m2, slot 2 is wb.
  rec_t mdl [PN][SN];

  fwd_source_tracker #(
    .DATA_WIDTH(DW), .STAGE_NUM(SN), .PIPE_NUM(PN), .LATE_STAGE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .ex_valid_i(ex_valid), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
    .ex_ready_i(ex_ready), .late_valid_i(late_valid), .late_data_i(late_data),
    .forwarding_bus_o(bus), .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic v, input logic r,
                                       input logic [4:0] a, input logic [DW-1:0] d);
    return {v, r, a, d};
  endfunction

  function automatic logic [DW-1:0] dval(input int a);
    return 32'hC0DE_0000 | a;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] m;
    m = '0;
    for (int p = 0; p < PN; p++)
      for (int i = 0; i < SN; i++)
        if (mdl[p][i].valid && !mdl[p][i].ready) m[mdl[p][i].addr] = 1'b1;
    return m;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    rec_t from_m1;
    rec_t from_m2;
    if (!rst_n) begin
      for (int p = 0; p < PN; p++)
        for (int i = 0; i < SN; i++) mdl[p][i] = '0;
    end else begin
      for (int p = 0; p < PN; p++) begin
        if (stall) begin
          if (flush) mdl[p][0].valid = 1'b0;
          if (late_valid[p] && mdl[p][1].valid && !mdl[p][1].ready) begin
            mdl[p][1].data  = late_data[p];
            mdl[p][1].ready = 1'b1;
          end
        end else begin
          from_m2 = mdl[p][1];
          if (late_valid[p] && from_m2.valid && !from_m2.ready) begin
            from_m2.data  = late_data[p];
            from_m2.ready = 1'b1;
          end
          from_m1 = mdl[p][0];
          if (flush) from_m1.valid = 1'b0;
          mdl[p][2] = from_m2;
          mdl[p][1] = from_m1;
          mdl[p][0].valid = ex_valid[p] && (ex_addr[p] != 5'd0) && !flush;
          mdl[p][0].ready = ex_ready[p];
          mdl[p][0].addr  = ex_addr[p];
          mdl[p][0].data  = ex_data[p];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    ex_valid = '0; ex_addr = '0; ex_data = '0; ex_ready = '0;
    late_valid = '0; late_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    ex_valid = 2'b11; ex_addr[0] = 5'd3; ex_addr[1] = 5'd4; ex_ready = 2'b00;
    tick();
    tick();
    for (int p = 0; p < PN; p++)
      for (int s = 0; s < SN; s++) begin
        total++;
        if (bus[p][s] !== '0)
          $display("[TB] FAIL reset_entry[%0d][%0d]: got %h expected 0", p, s, bus[p][s]);
        else passed++;
      end
    total++;
    if (pending !== 32'd0) $display("[TB] FAIL reset_pending: got %h expected 0", pending);
    else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_basic_capture();
    idle_inputs();
    ex_valid = 2'b01; ex_addr[0] = 5'd5; ex_data[0] = 32'hDEAD; ex_ready = 2'b01;
    tick();
    idle_inputs();
    total++;
    if (bus[0][2] !== mk(1'b1, 1'b1, 5'd5, 32'hDEAD))
      $display("[TB] FAIL capture_m1: got %h expected %h", bus[0][2], mk(1'b1, 1'b1, 5'd5, 32'hDEAD));
    else passed++;
    tick();
    tick();
    total++;
    if (bus[0][0] !== mk(1'b1, 1'b1, 5'd5, 32'hDEAD))
      $display("[TB] FAIL capture_wb: got %h expected %h", bus[0][0], mk(1'b1, 1'b1, 5'd5, 32'hDEAD));
    else passed++;
    tick();
    total++;
    if (bus[0][0][EW-1] !== 1'b0) $display("[TB] FAIL capture_retired: got valid %b expected 0", bus[0][0][EW-1]);
    else passed++;
  endtask

  task automatic test_late_load();
    idle_inputs();
    ex_valid = 2'b10; ex_addr[1] = 5'd7; ex_data[1] = 32'h0BAD; ex_ready = 2'b00;
    tick();
    idle_inputs();
    total++;
    if (pending !== 32'h80) $display("[TB] FAIL load_pending_m1: got %h expected 00000080", pending);
    else passed++;
    tick();
    total++;
    if (pending !== 32'h80) $display("[TB] FAIL load_pending_m2: got %h expected 00000080", pending);
    else passed++;
    late_valid = 2'b10; late_data[1] = 32'h1234;
    tick();
    idle_inputs();
    total++;
    if (bus[1][0] !== mk(1'b1, 1'b1, 5'd7, 32'h1234))
      $display("[TB] FAIL load_late_wb: got %h expected %h", bus[1][0], mk(1'b1, 1'b1, 5'd7, 32'h1234));
    else passed++;
    total++;
    if (pending !== 32'd0) $display("[TB] FAIL load_pending_clear: got %h expected 0", pending);
    else passed++;
    tick();
  endtask

  task automatic test_r0_drop();
    idle_inputs();
    ex_valid = 2'b01; ex_addr[0] = 5'd9; ex_ready = 2'b00; ex_data[0] = dval(9);
    tick();
    ex_valid = 2'b11; ex_addr[0] = 5'd0; ex_addr[1] = 5'd0; ex_ready = 2'b00;
    tick();
    idle_inputs();
    for (int p = 0; p < PN; p++) begin
      total++;
      if (bus[p][2][EW-1] !== 1'b0) $display("[TB] FAIL r0_valid[%0d]: got %b expected 0", p, bus[p][2][EW-1]);
      else passed++;
    end
    total++;
    if (pending !== 32'h200) $display("[TB] FAIL r0_pending: got %h expected 00000200", pending);
    else passed++;
    late_valid = 2'b01; late_data[0] = 32'h99;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    logic [PN-1:0][SN-1:0][EW-1:0] exp;
    idle_inputs();
    ex_valid = 2'b11; ex_ready = 2'b11;
    ex_addr[0] = 5'd10; ex_addr[1] = 5'd11; ex_data[0] = dval(10); ex_data[1] = dval(11);
    tick();
    ex_ready = 2'b10;
    ex_addr[0] = 5'd12; ex_addr[1] = 5'd13; ex_data[0] = dval(12); ex_data[1] = dval(13);
    tick();
    ex_ready = 2'b11;
    ex_addr[0] = 5'd14; ex_addr[1] = 5'd15; ex_data[0] = dval(14); ex_data[1] = dval(15);
    tick();
    exp[0][2] = mk(1'b1, 1'b1, 5'd14, dval(14)); exp[1][2] = mk(1'b1, 1'b1, 5'd15, dval(15));
    exp[0][1] = mk(1'b1, 1'b0, 5'd12, dval(12)); exp[1][1] = mk(1'b1, 1'b1, 5'd13, dval(13));
    exp[0][0] = mk(1'b1, 1'b1, 5'd10, dval(10)); exp[1][0] = mk(1'b1, 1'b1, 5'd11, dval(11));
    stall = 1'b1;
    ex_addr[0] = 5'd30; ex_addr[1] = 5'd31; ex_data[0] = 32'hFFFF; ex_data[1] = 32'hEEEE;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus !== exp) $display("[TB] FAIL stall_hold_%0d: got %h expected %h", c, bus, exp);
      else passed++;
    end
    total++;
    if (pending !== 32'h1000) $display("[TB] FAIL stall_pending: got %h expected 00001000", pending);
    else passed++;
    late_valid = 2'b01; late_data[0] = 32'h5555;
    tick();
    late_valid = '0;
    exp[0][1] = mk(1'b1, 1'b1, 5'd12, 32'h5555);
    total++;
    if (bus !== exp) $display("[TB] FAIL stall_late: got %h expected %h", bus, exp);
    else passed++;
    total++;
    if (pending !== 32'd0) $display("[TB] FAIL stall_late_pending: got %h expected 0", pending);
    else passed++;
    idle_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    ex_valid = 2'b01; ex_ready = 2'b01; ex_addr[0] = 5'd4; ex_data[0] = dval(4);
    tick();
    ex_addr[0] = 5'd3; ex_data[0] = dval(3);
    tick();
    flush = 1'b1; ex_addr[0] = 5'd6; ex_data[0] = dval(6);
    tick();
    flush = 1'b0;
    total++;
    if (bus[0][1] !== mk(1'b0, 1'b1, 5'd3, dval(3)))
      $display("[TB] FAIL flush_m2: got %h expected %h", bus[0][1], mk(1'b0, 1'b1, 5'd3, dval(3)));
    else passed++;
    total++;
    if (bus[0][0] !== mk(1'b1, 1'b1, 5'd4, dval(4)))
      $display("[TB] FAIL flush_wb: got %h expected %h", bus[0][0], mk(1'b1, 1'b1, 5'd4, dval(4)));
    else passed++;
    total++;
    if (bus[0][2][EW-1] !== 1'b0) $display("[TB] FAIL flush_m1: got valid %b expected 0", bus[0][2][EW-1]);
    else passed++;
    ex_addr[0] = 5'd8; ex_data[0] = dval(8);
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    total++;
    if (bus[0][2] !== mk(1'b0, 1'b1, 5'd8, dval(8)))
      $display("[TB] FAIL flush_stall_m1: got %h expected %h", bus[0][2], mk(1'b0, 1'b1, 5'd8, dval(8)));
    else passed++;
    total++;
    if (bus[0][1] !== mk(1'b0, 1'b1, 5'd6, dval(6)))
      $display("[TB] FAIL flush_stall_m2: got %h expected %h", bus[0][1], mk(1'b0, 1'b1, 5'd6, dval(6)));
    else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    ex_valid = 2'b11; ex_ready = 2'b00;
    ex_addr[0] = 5'd20; ex_addr[1] = 5'd21;
    tick();
    ex_ready = 2'b01; ex_addr[0] = 5'd22; ex_addr[1] = 5'd23;
    tick();
    idle_inputs();
    total++;
    if (pending !== 32'h00B0_0000) $display("[TB] FAIL midreset_pending_before: got %h expected 00b00000", pending);
    else passed++;
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0;
    tick();
    total++;
    if (pending !== 32'd0) $display("[TB] FAIL midreset_pending: got %h expected 0", pending);
    else passed++;
    for (int p = 0; p < PN; p++)
      for (int s = 0; s < SN; s++) begin
        total++;
        if (bus[p][s][EW-1] !== 1'b0) $display("[TB] FAIL midreset_valid[%0d][%0d]: got 1 expected 0", p, s);
        else passed++;
      end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [EW-1:0] exp_e;
    logic [31:0]   exp_p;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < PN; p++) begin
        ex_valid[p]   = $urandom_range(0, 3) != 0;
        ex_addr[p]    = 5'($urandom_range(0, 9));
        ex_data[p]    = $urandom;
        ex_ready[p]   = $urandom_range(0, 1) == 1;
        late_valid[p] = $urandom_range(0, 3) == 0;
        late_data[p]  = $urandom;
        // A waiting result about to leave m2 must receive its late data.
        if (!stall && mdl[p][1].valid && !mdl[p][1].ready) late_valid[p] = 1'b1;
      end
      tick();
      for (int p = 0; p < PN; p++)
        for (int s = 0; s < SN; s++) begin
          exp_e = mdl[p][SN-1-s];
          total++;
          if (bus[p][s] !== exp_e)
            $display("[TB] FAIL rand_bus[%0d][%0d] cycle %0d: got %h expected %h", p, s, c, bus[p][s], exp_e);
          else passed++;
        end
      exp_p = model_pending();
      total++;
      if (pending !== exp_p) $display("[TB] FAIL rand_pending cycle %0d: got %h expected %h", c, pending, exp_p);
      else passed++;
    end
    idle_inputs();
    stall = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    for (int p = 0; p < PN; p++)
      for (int i = 0; i < SN; i++) mdl[p][i] = '0;
    idle_inputs();
    test_reset();
    test_basic_capture();
    test_late_load();
    test_r0_drop();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
